sm_addsub_pipe: RTL and testbench

SM_ADDSUB_PIPE -- requirements
Module: sm_addsub_pipe

---
 rtl/sm_addsub_pipe.sv | 116 +++++++++++
 tb/tb_sm_addsub_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_addsub_pipe.sv
// Two-stage sign-magnitude adder/subtractor with valid/ready flow control.
// S1 holds the operand magnitudes, their signs and the magnitude compare; S2 holds the result.
module sm_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             ovf
);
  localparam int MW = WIDTH - 1;

  logic          rdy_q, rdy_d;
  logic          s1_valid_q, s1_valid_d;
  logic          s1_sa_q, s1_sa_d;
  logic          s1_sb_q, s1_sb_d;
  logic          s1_gt_q, s1_gt_d;
  logic          s1_eq_q, s1_eq_d;
  logic [MW-1:0] s1_ma_q, s1_ma_d;
  logic [MW-1:0] s1_mb_q, s1_mb_d;
  logic          out_valid_q, out_valid_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic          ovf_q, ovf_d;

  logic          out_adv, s1_adv, accept;
  logic [MW:0]   sum;
  logic [MW-1:0] diff, mag;
  logic          sign, ovf_n;

  // Handshake: a stage moves only when the stage after it is free or draining now.
  always_comb begin
    out_adv  = !out_valid_q || out_ready;
    s1_adv   = s1_valid_q && out_adv;
    in_ready = rdy_q && (!s1_valid_q || s1_adv);
    accept   = in_valid && in_ready;
  end

  always_comb begin
    rdy_d      = 1'b1;
    s1_valid_d = accept ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
    s1_sa_d    = s1_sa_q;
    s1_sb_d    = s1_sb_q;
    s1_gt_d    = s1_gt_q;
    s1_eq_d    = s1_eq_q;
    s1_ma_d    = s1_ma_q;
    s1_mb_d    = s1_mb_q;
    if (accept) begin
      s1_sa_d = a[WIDTH-1];
      s1_sb_d = b[WIDTH-1] ^ sub;
      s1_ma_d = a[MW-1:0];
      s1_mb_d = b[MW-1:0];
      s1_gt_d = a[MW-1:0] > b[MW-1:0];
      s1_eq_d = a[MW-1:0] == b[MW-1:0];
    end
  end

  always_comb begin
    sum   = {1'b0, s1_ma_q} + {1'b0, s1_mb_q};
    diff  = s1_gt_q ? (s1_ma_q - s1_mb_q) : (s1_mb_q - s1_ma_q);
    mag   = diff;
    sign  = s1_eq_q ? 1'b0 : (s1_gt_q ? s1_sa_q : s1_sb_q);
    ovf_n = 1'b0;
    if (s1_sa_q == s1_sb_q) begin
      mag   = sum[MW-1:0];
      sign  = s1_sa_q;
      ovf_n = sum[MW];
      if (SAT && sum[MW]) mag = '1;
    end
    // Zero magnitude is always reported as +0, including wrapped overflow.
    if (mag == '0) sign = 1'b0;

    out_valid_d = s1_adv || (out_valid_q && !out_ready);
    c_d         = s1_adv ? {sign, mag} : c_q;
    ovf_d       = s1_adv ? ovf_n : ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_sa_q     <= 1'b0;
      s1_sb_q     <= 1'b0;
      s1_gt_q     <= 1'b0;
      s1_eq_q     <= 1'b0;
      s1_ma_q     <= '0;
      s1_mb_q     <= '0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      ovf_q       <= 1'b0;
    end else begin
      rdy_q       <= rdy_d;
      s1_valid_q  <= s1_valid_d;
      s1_sa_q     <= s1_sa_d;
      s1_sb_q     <= s1_sb_d;
      s1_gt_q     <= s1_gt_d;
      s1_eq_q     <= s1_eq_d;
      s1_ma_q     <= s1_ma_d;
      s1_mb_q     <= s1_mb_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Bench for sm_addsub_pipe: a saturating and a wrapping instance share one input stream
// and are checked against a signed-integer reference model.
module tb_sm_addsub_pipe;
  localparam int W = 32;
  localparam longint MAXM = (64'sd1 <<< (W-1)) - 1;

  logic clk, rst_n, in_valid, sub, out_ready;
  logic [W-1:0] a, b;
  logic in_ready, out_valid, ovf, in_ready0, out_valid0, ovf0;
  logic [W-1:0] c, c0;
  int n_cmp, n_err;

  sm_addsub_pipe #(.WIDTH(W), .SAT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .c(c), .ovf(ovf));
  sm_addsub_pipe #(.WIDTH(W), .SAT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b),
    .sub(sub), .out_valid(out_valid0), .out_ready(out_ready), .c(c0), .ovf(ovf0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret as signed integers, add, then re-encode as sign-magnitude.
  function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic s, input bit sat);
    longint mx, my, vx, vy, r, m;
    logic neg, o;
    logic [W-2:0] mm;
    mx = longint'(x[W-2:0]);
    my = longint'(y[W-2:0]);
    vx = x[W-1] ? -mx : mx;
    vy = (y[W-1] ^ s) ? -my : my;
    r = vx + vy;
    neg = r < 0;
    m = neg ? -r : r;
    o = m > MAXM;
    if (o) m = sat ? MAXM : (m % (MAXM + 1));
    if (m == 0) neg = 1'b0;
    mm = m[W-2:0];
    return {o, neg, mm};
  endfunction

  function automatic logic [W-1:0] rnd_val();
    logic [W-2:0] m;
    case ($urandom_range(0, 4))
      0: m = '0;
      1: m = '1;
      2: m = W'($urandom_range(0, 15));
      3: m = {1'b1, 30'($urandom)};
      default: m = 31'($urandom);
    endcase
    return {1'($urandom), m};
  endfunction

  task automatic new_op();
    a = rnd_val();
    b = rnd_val();
    sub = 1'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({out_valid, ovf, c, in_ready} !== '0 || {out_valid0, ovf0, c0, in_ready0} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got ov=%b ovf=%b c=%h ir=%b / ov0=%b ovf0=%b c0=%h ir0=%b, want all 0",
               out_valid, ovf, c, in_ready, out_valid0, ovf0, c0, in_ready0);
    end
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL ready_before_edge: got %b want 0", in_ready);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || in_ready0 !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL ready_after_release: got ir=%b ir0=%b ov=%b want 1 1 0", in_ready, in_ready0, out_valid);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [10], vb [10], e1 [10], e0 [10];
    logic vs [10], o1 [10], o0 [10];
    va = '{32'h00000005, 32'h00000007, 32'h80000000, 32'h7FFFFFFF, 32'h80000004,
           32'h80000000, 32'hFFFFFFFF, 32'h40000000, 32'h00000003, 32'h7FFFFFFF};
    vb = '{32'h80000003, 32'h00000007, 32'h80000000, 32'h00000001, 32'h00000009,
           32'h00000005, 32'hFFFFFFFF, 32'h40000000, 32'h80000008, 32'hFFFFFFFF};
    vs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    e1 = '{32'h00000002, 32'h00000000, 32'h00000000, 32'h7FFFFFFF, 32'h8000000D,
           32'h80000005, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000005, 32'h00000000};
    o1 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    e0 = '{32'h00000002, 32'h00000000, 32'h00000000, 32'h00000000, 32'h8000000D,
           32'h80000005, 32'hFFFFFFFE, 32'h00000000, 32'h80000005, 32'h00000000};
    o0 = o1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = va[i]; b = vb[i]; sub = vs[i]; out_ready = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL vec%0d_in_ready: got %b want 1", i, in_ready); end
      @(negedge clk) in_valid = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL vec%0d_early: out_valid got %b want 0", i, out_valid); end
      @(negedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || {ovf, c} !== {o1[i], e1[i]}) begin
        n_err++; $display("FAIL vec%0d_sat: got v=%b ovf=%b c=%h want v=1 ovf=%b c=%h", i, out_valid, ovf, c, o1[i], e1[i]);
      end
      n_cmp++;
      if (out_valid0 !== 1'b1 || {ovf0, c0} !== {o0[i], e0[i]}) begin
        n_err++; $display("FAIL vec%0d_wrap: got v=%b ovf=%b c=%h want v=1 ovf=%b c=%h", i, out_valid0, ovf0, c0, o0[i], e0[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] q1 [$], q0 [$];
    logic hold;
    logic [2*W+1:0] prev;
    int sent, got, t;
    sent = 0; got = 0; t = 0; hold = 1'b0; prev = '0;
    new_op();
    while (got < 4 && t < 40) begin
      @(negedge clk);
      in_valid = sent < 4;
      out_ready = !(t >= 2 && t <= 5);
      #1;
      if (t >= 2 && t <= 5) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_t%0d: in_ready got %b want 0", t, in_ready); end
      end
      if (hold) begin
        n_cmp++;
        if (out_valid !== 1'b1 || {ovf, c, ovf0, c0} !== prev) begin
          n_err++; $display("FAIL b2b_stable_t%0d: got v=%b %h want v=1 %h", t, out_valid, {ovf, c, ovf0, c0}, prev);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if ({ovf, c} !== q1[0] || {ovf0, c0} !== q0[0] || out_valid0 !== 1'b1) begin
          n_err++; $display("FAIL b2b_result%0d: got %h/%h want %h/%h", got, {ovf, c}, {ovf0, c0}, q1[0], q0[0]);
        end
        void'(q1.pop_front()); void'(q0.pop_front()); got++;
      end
      hold = out_valid && !out_ready;
      prev = {ovf, c, ovf0, c0};
      if (in_valid && in_ready) begin
        q1.push_back(ref_op(a, b, sub, 1'b1));
        q0.push_back(ref_op(a, b, sub, 1'b0));
        sent++;
        @(posedge clk); #1 new_op();
      end
      t++;
    end
    n_cmp++;
    if (got != 4) begin n_err++; $display("FAIL b2b_timeout: got %0d results want 4", got); end
    @(negedge clk) in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [W:0] e1;
    @(negedge clk);
    in_valid = 1'b1; a = 32'h00000010; b = 32'h00000020; sub = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_during: out_valid got %b want 0", out_valid); end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_valid0 !== 1'b0) begin
        n_err++; $display("FAIL rstmid_ghost%0d: out_valid got %b/%b want 0", i, out_valid, out_valid0);
      end
    end
    @(negedge clk);
    in_valid = 1'b1; a = 32'h80000030; b = 32'h80000011; sub = 1'b1;
    e1 = ref_op(a, b, sub, 1'b1);
    @(negedge clk) in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_early: out_valid got %b want 0", out_valid); end
    @(negedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || {ovf, c} !== e1) begin
      n_err++; $display("FAIL rstmid_result: got v=%b %h want v=1 %h", out_valid, {ovf, c}, e1);
    end
  endtask

  task automatic test_random();
    logic [W:0] q1 [$], q0 [$];
    logic hold, need;
    logic [2*W+1:0] prev;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; hold = 1'b0; need = 1'b1; prev = '0;
    while (got < 400 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (need) begin new_op(); need = 1'b0; end
      in_valid = (sent < 400) && ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (hold) begin
        n_cmp++;
        if (out_valid !== 1'b1 || {ovf, c, ovf0, c0} !== prev) begin
          n_err++; $display("FAIL rnd_stable_c%0d: got v=%b %h want v=1 %h", cyc, out_valid, {ovf, c, ovf0, c0}, prev);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q1.size() == 0) begin
          n_err++; $display("FAIL rnd_extra_c%0d: got result %h want none", cyc, {ovf, c});
        end else begin
          if ({ovf, c} !== q1[0] || {ovf0, c0} !== q0[0] || out_valid0 !== 1'b1) begin
            n_err++; $display("FAIL rnd_result%0d: got %h/%h want %h/%h", got, {ovf, c}, {ovf0, c0}, q1[0], q0[0]);
          end
          void'(q1.pop_front()); void'(q0.pop_front());
        end
        got++;
      end
      hold = out_valid && !out_ready;
      prev = {ovf, c, ovf0, c0};
      if (in_valid && in_ready) begin
        q1.push_back(ref_op(a, b, sub, 1'b1));
        q0.push_back(ref_op(a, b, sub, 1'b0));
        sent++;
        need = 1'b1;
      end
    end
    n_cmp++;
    if (got != 400) begin n_err++; $display("FAIL rnd_timeout: got %0d results want 400", got); end
    @(negedge clk) in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
